// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared width, latency and state definitions for the sequential divider
package div_pkg;

    localparam int DIV_WIDTH   = 32;
    localparam int DIV_CNT_W   = $clog2(DIV_WIDTH);
    // start edge + DIV_WIDTH restoring steps + one sign-fix cycle
    localparam int DIV_LATENCY = DIV_WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
//
// Ports:
//   rem, quo      partial remainder and quotient/dividend shift register
//   divisor       divisor magnitude
//   rem_next      partial remainder after this step
//   quo_next      shift register after this step, new quotient bit in [0]
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        // {rem, quo} << 1; the extra bit keeps the trial subtract from wrapping
        shifted = {rem, quo[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - sequential signed restoring divider (quotient on lo, remainder on hi)
//
// Optional feature macro: DIV_UNSIGNED_EN adds input is_unsigned for DIVU.
//
// Ports:
//   clock         system clock, rising edge
//   reset         synchronous active-high reset
//   start         request, sampled only in IDLE
//   dividend      A operand, captured on accepted start
//   divisor       B operand, captured on accepted start
//   is_unsigned   (DIV_UNSIGNED_EN only) treat operands as unsigned
//   hi            remainder, held until next completion
//   lo            quotient, held until next completion
//   busy          high whenever the FSM is not in IDLE
//   done          one-cycle completion pulse
//   div_zero      divisor was zero; valid with done, cleared on next accepted start
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_UNSIGNED_EN
    input  logic             is_unsigned,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_e state;
    div_state_e state_next;

    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [CNT_W-1:0] cnt;
    logic             quo_neg;
    logic             rem_neg;

    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             divisor_zero;

`ifdef DIV_UNSIGNED_EN
    assign signed_op = ~is_unsigned;
`else
    assign signed_op = 1'b1;
`endif

    // Magnitudes stay unsigned WIDTH bits, so the most negative value maps to 2^(WIDTH-1)
    assign a_neg        = signed_op & dividend[WIDTH-1];
    assign b_neg        = signed_op & divisor[WIDTH-1];
    assign a_mag        = a_neg ? (~dividend + 1'b1) : dividend;
    assign b_mag        = b_neg ? (~divisor + 1'b1) : divisor;
    assign divisor_zero = (divisor == '0);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dvsr),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = divisor_zero ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            cnt      <= '0;
            quo_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor_zero) begin
                            // hi/lo intentionally left holding the previous result
                            div_zero <= 1'b1;
                        end else begin
                            rem      <= '0;
                            quo      <= a_mag;
                            dvsr     <= b_mag;
                            quo_neg  <= a_neg ^ b_neg;
                            rem_neg  <= a_neg;
                            cnt      <= CNT_W'(WIDTH - 1);
                            div_zero <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt - 1'b1;
                end
                FIX: begin
                    lo <= quo_neg ? (~quo + 1'b1) : quo;
                    hi <= rem_neg ? (~rem + 1'b1) : rem;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - self-checking bench for div_seq with a cycle-level reference model
module tb_div_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        is_uns = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    div_seq dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
`ifdef DIV_UNSIGNED_EN
        .is_unsigned (is_uns),
`endif
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a countdown of busy cycles plus arithmetic results from 64-bit math
    int          m_left = 0;
    bit          m_zero = 1'b0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;
    logic        exp_dz = 1'b0;
    logic [31:0] p_hi = '0;
    logic [31:0] p_lo = '0;

    always @(posedge clock) begin
        longint sa;
        longint sb;
        bit     sgn;
        if (reset) begin
            m_left = 0;
            exp_hi = '0;
            exp_lo = '0;
            exp_dz = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 1 && !m_zero) begin
                exp_lo = p_lo;
                exp_hi = p_hi;
            end
        end else if (start) begin
            if (divisor == 32'd0) begin
                m_left = 1;
                m_zero = 1'b1;
                exp_dz = 1'b1;
            end else begin
`ifdef DIV_UNSIGNED_EN
                sgn = !is_uns;
`else
                sgn = 1'b1;
`endif
                sa = sgn ? longint'($signed(dividend)) : longint'({32'd0, dividend});
                sb = sgn ? longint'($signed(divisor)) : longint'({32'd0, divisor});
                p_lo   = 32'(sa / sb);
                p_hi   = 32'(sa % sb);
                m_left = 34;
                m_zero = 1'b0;
                exp_dz = 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_left != 0));
            chk("done", 32'(done), 32'(m_left == 1));
            chk("div_zero", 32'(div_zero), 32'(exp_dz));
            chk("hi", hi, exp_hi);
            chk("lo", lo, exp_lo);
        end
    end

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic u, output int lat);
        @(negedge clock);
        dividend = a;
        divisor  = b;
        is_uns   = u;
        start    = 1'b1;
        lat = 0;
        do begin
            @(negedge clock);
            start = 1'b0;
            lat++;
            // scribble operands after capture; the result must not change
            dividend = 32'hDEAD_BEEF ^ 32'(lat);
            divisor  = 32'(lat);
        end while (!done && lat < 100);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        u;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int lat;
        int ndone;
        tbl = '{
            '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0},
            '{32'd7,          32'd0,          1'b0, 32'd14,         32'd2,          1'b1},
            '{32'hFFFF_FF9C,  32'd7,          1'b0, 32'hFFFF_FFF2,  32'hFFFF_FFFE,  1'b0},
            '{32'd100,        32'hFFFF_FFF9,  1'b0, 32'hFFFF_FFF2,  32'd2,          1'b0},
            '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000,  32'd0,          1'b0},
            '{32'd7,          32'd100,        1'b0, 32'd0,          32'd7,          1'b0},
            '{32'h8000_0000,  32'd1,          1'b0, 32'h8000_0000,  32'd0,          1'b0},
            '{32'h7FFF_FFFF,  32'h8000_0000,  1'b0, 32'd0,          32'h7FFF_FFFF,  1'b0},
            '{32'hFFFF_FFF9,  32'hFFFF_FFF9,  1'b0, 32'd1,          32'd0,          1'b0},
            '{32'd0,          32'd0,          1'b0, 32'd1,          32'd0,          1'b1},
            '{32'd0,          32'd5,          1'b0, 32'd0,          32'd0,          1'b0}
        };

        repeat (3) @(negedge clock);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_div_zero", 32'(div_zero), 32'd0);
        reset  = 1'b0;
        chk_en = 1'b1;

        foreach (tbl[i]) begin
            run_div(tbl[i].a, tbl[i].b, tbl[i].u, lat);
            chk("latency", 32'(lat), tbl[i].dz ? 32'd1 : 32'd34);
            chk("vec_lo", lo, tbl[i].lo);
            chk("vec_hi", hi, tbl[i].hi);
            chk("vec_div_zero", 32'(div_zero), 32'(tbl[i].dz));
            chk("model_lo", exp_lo, tbl[i].lo);
            chk("model_hi", exp_hi, tbl[i].hi);
        end

        // reset in the middle of a 50/3 division
        @(negedge clock);
        dividend = 32'd50;
        divisor  = 32'd3;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("midreset_hi", hi, 32'd0);
        chk("midreset_lo", lo, 32'd0);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        reset = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) ndone++;
        end
        chk("no_done_after_reset", 32'(ndone), 32'd0);

        // 9/4 with a second start pulsed mid-operation
        @(negedge clock);
        dividend = 32'd9;
        divisor  = 32'd4;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(negedge clock);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(negedge clock);
        start = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) ndone++;
        end
        chk("single_done", 32'(ndone), 32'd1);
        chk("ignored_start_lo", lo, 32'd2);
        chk("ignored_start_hi", hi, 32'd1);

`ifdef DIV_UNSIGNED_EN
        run_div(32'hFFFF_FFFF, 32'd2, 1'b1, lat);
        chk("divu_latency", 32'(lat), 32'd34);
        chk("divu_lo", lo, 32'h7FFF_FFFF);
        chk("divu_hi", hi, 32'd1);
        run_div(32'hFFFF_FFFF, 32'd2, 1'b0, lat);
        chk("div_signed_lo", lo, 32'd0);
        chk("div_signed_hi", hi, 32'hFFFF_FFFF);
`endif

        repeat (2) @(negedge clock);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/div_seq.md
# div_seq

Sequential signed restoring divider serving the DIV instruction of the multicycle MIPS core. It takes operands from the A/B operand registers and produces quotient (LO) and remainder (HI) for the HI/LO write-back muxes. It signals completion with a one-cycle `done` pulse, which the control unit waits on before asserting HIWrite/LOWrite. Divide-by-zero is flagged to the control unit so it can raise the exception path.

## Interface
- `WIDTH`, 32, operand/result width in bits; the core always uses 32.
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; one clock, synchronous active-high reset, shared with the rest of the core.
- `start`  in  1  request; sampled only in IDLE.
- `dividend`  in  WIDTH  A register value; captured on accepted start.
- `divisor`  in  WIDTH  B register value; captured on accepted start.
- `hi`  out  WIDTH  remainder; registered; holds until next completion.
- `lo`  out  WIDTH  quotient; registered; holds until next completion.
- `busy`  out  1  high from the cycle after an accepted start until `done`, inclusive.
- `done`  out  1  one-cycle completion pulse.
- `div_zero`  out  1  high with `done` when divisor was 0; cleared on next accepted start.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - `start`=1, divisor≠0 → capture |dividend|, |divisor|, quotient sign (sign(a) xor sign(b)), remainder sign (sign(a)); load step counter WIDTH-1; go CALC.
  - `start`=1, divisor=0 → go DONE with `div_zero` set; `hi`/`lo` are not updated.
- CALC: one restoring step per cycle.
  - Shift {rem, quo} left by 1.
  - Trial subtract rem − |divisor| in WIDTH+1 bits.
  - If non-negative, keep the difference and set quo[0]=1.
  - Counter decrements; go FIX after the step where counter is 0, i.e. WIDTH steps total.
- FIX: apply signs (two's-complement negate where required); write `lo`=quotient and `hi`=remainder; go DONE.
- DONE: `done`=1 for exactly this cycle; return to IDLE.
- Semantics:
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - Magnitudes are unsigned WIDTH bits, so |−2^31| = 2^31 is representable.
  - 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0, no flag.
- `start` asserted outside IDLE is ignored, with no queuing; operand changes after capture have no effect.
- `reset` at any cycle (including mid-CALC) → IDLE; `hi`=`lo`=0, `busy`=`done`=`div_zero`=0; an in-flight result is discarded.
- Reset values: all outputs 0.

## Timing
- Edge S samples `start` (IDLE).
- CALC occupies edges S+1…S+WIDTH; FIX completes at edge S+WIDTH+1.
- `done` is high in the cycle following edge S+WIDTH+1, i.e. 34 cycles after start for WIDTH=32. `hi`/`lo` are valid in that same cycle and afterwards.
- Divide-by-zero: `done` and `div_zero` are high in the cycle after edge S (latency 1).
- Back-to-back operation: a new `start` is accepted in the cycle after `done` (IDLE).
- `busy` equals (state ≠ IDLE).

## Configuration
- `DIV_UNSIGNED_EN` defined:
  - Adds input `is_unsigned` (1 bit), sampled with `start`.
  - When 1, operands are taken as unsigned: no abs, no sign fix, and FIX still costs one cycle so latency is unchanged.
  - Serves DIVU.
- `DIV_UNSIGNED_EN` undefined: the port is absent and all divisions are signed.

## Structure
- Shared package `div_pkg` holds:
  - the state enum (IDLE/CALC/FIX/DONE);
  - `DIV_WIDTH`=32;
  - `DIV_CNT_W`=$clog2(DIV_WIDTH);
  - `DIV_LATENCY`=DIV_WIDTH+2, which the control unit uses for its wait-state assertions.
- One sub-module, `div_step`: combinational single restoring iteration taking (rem, quo, divisor) and returning (rem', quo'). It is instantiated once in CALC.

## Test plan
- 100 / 7 → `lo`=14, `hi`=2; `done` pulses exactly 34 cycles after start; `busy` high for cycles 1–34.
- −100 / 7 → `lo`=0xFFFFFFF2, `hi`=0xFFFFFFFE. Also 100 / −7 → `lo`=0xFFFFFFF2, `hi`=2.
- 7 / 0 → `done` and `div_zero` high the next cycle; `hi`/`lo` keep their previous 14/2.
- 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0, `div_zero`=0.
- Start 50/3, pulse `reset` at cycle 10 → all outputs 0 the next cycle, no `done`. A subsequent start of 9/4 gives `lo`=2, `hi`=1. A second `start` pulsed during that operation is ignored (single `done`).
- With `DIV_UNSIGNED_EN`: 0xFFFFFFFF / 2 with `is_unsigned`=1 → `lo`=0x7FFFFFFF, `hi`=1. The same operands with `is_unsigned`=0 → `lo`=0, `hi`=0xFFFFFFFF.
